// File: rtl/tff_seq_pkg.sv
// tff_seq_pkg: shared state encodings and direction constants for the TFF count sequencer.
package tff_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/tff_count_sequencer_if.sv
// tff_count_sequencer_if: command handshake and status bundle between controller and sequencer.
interface tff_count_sequencer_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_load;
  logic [WIDTH-1:0] cmd_limit;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  modport master (output cmd_valid, cmd_dir, cmd_load, cmd_limit, abort,
                  input  cmd_ready, count, busy, done);
  modport slave  (input  cmd_valid, cmd_dir, cmd_load, cmd_limit, abort,
                  output cmd_ready, count, busy, done);
endinterface

// File: rtl/tff.sv
// tff: single T flip-flop built from a DFF with t^q feedback.
module tff (
  input  logic clk,
  input  logic reset,
  input  logic t_i,
  output logic q_o
);
  always_ff @(posedge clk)
    if (reset) q_o <= 1'b0;
    else       q_o <= q_o ^ t_i;
endmodule

// File: rtl/tff_bank.sv
// tff_bank: WIDTH parallel T flip-flops driven by a per-bit toggle vector.
module tff_bank #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t_vec_i,
  output logic [WIDTH-1:0] q_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    tff u_tff (.clk(clk), .reset(reset), .t_i(t_vec_i[i]), .q_o(q_o[i]));
  end
endmodule

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: loads a start value into a TFF bank and counts up/down to a limit, pulsing done.
// Build option TFF_SEQ_AUTORELOAD_EN: reload and repeat at the limit until abort or reset.
module tff_count_sequencer
  import tff_seq_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic reset,
  tff_count_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic             dir_q;
  logic [WIDTH-1:0] load_q, limit_q;
  logic [WIDTH-1:0] count, t_vec, up_t, dn_t;
  logic             accept, match;
  assign bus.cmd_ready = (state_q == IDLE) & ~reset;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign match         = count == limit_q;
  assign bus.count     = count;
  assign bus.busy      = (state_q == LOAD) | (state_q == RUN);
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  // Bit i toggles when all lower bits are 1 (carry) or all 0 (borrow)
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign up_t[i] = &count[i-1:0];
    assign dn_t[i] = &(~count[i-1:0]);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      load_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q   <= bus.cmd_dir;
        load_q  <= bus.cmd_load;
        limit_q <= bus.cmd_limit;
      end
    end
  always_comb begin
    state_d  = state_q;
    t_vec    = '0;
    bus.done = 1'b0;
    unique case (state_q)
      IDLE: state_d = accept ? LOAD : IDLE;
      LOAD: begin
        state_d = bus.abort ? IDLE : RUN;
        t_vec   = bus.abort ? '0 : count ^ load_q;
      end
      RUN: begin
        if (bus.abort) state_d = IDLE;
        else if (match) begin
`ifdef TFF_SEQ_AUTORELOAD_EN
          state_d  = LOAD;
          bus.done = 1'b1;
`else
          state_d  = DONE;
`endif
        end else t_vec = (dir_q == DIR_UP) ? up_t : dn_t;
      end
      DONE: begin
        state_d  = IDLE;
        bus.done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk(clk), .reset(reset), .t_vec_i(t_vec), .q_o(count)
  );
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: directed scoreboard bench for the TFF count sequencer (WIDTH=8).
module tb_tff_count_sequencer;
  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       d;
    logic       r;
    string      tag;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  tff_count_sequencer_if #(.WIDTH(8)) bus ();
  tff_count_sequencer #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  int passed = 0;
  int total  = 0;
  ent_t sb[$];
  logic [7:0] cur = 8'h00;
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic push(string tag, logic [7:0] c, logic b, logic d, logic r);
    sb.push_back('{c, b, d, r, tag});
  endtask
  // Expected per-cycle trace after the accept edge: LOAD, RUN load..limit, DONE, IDLE
  task automatic trace(string tag, logic dir, logic [7:0] ld, logic [7:0] lim, int n);
    ent_t t[$];
    logic [7:0] s;
    s = dir ? lim - ld : ld - lim;
    t.push_back('{cur, 1'b1, 1'b0, 1'b0, {tag, ".load"}});
    for (int j = 0; j <= int'(s); j++)
      t.push_back('{dir ? ld + 8'(j) : ld - 8'(j), 1'b1, 1'b0, 1'b0, $sformatf("%s.run%0d", tag, j)});
    t.push_back('{lim, 1'b0, 1'b1, 1'b0, {tag, ".done"}});
    t.push_back('{lim, 1'b0, 1'b0, 1'b1, {tag, ".idle"}});
    for (int i = 0; i < t.size() && (n < 0 || i < n); i++) sb.push_back(t[i]);
    cur = sb[$].c;
  endtask
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/count"}, bus.count, e.c);
      chk({e.tag, "/busy"}, {7'd0, bus.busy}, {7'd0, e.b});
      chk({e.tag, "/done"}, {7'd0, bus.done}, {7'd0, e.d});
      chk({e.tag, "/ready"}, {7'd0, bus.cmd_ready}, {7'd0, e.r});
      if (sb.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic send(logic dir, logic [7:0] ld, logic [7:0] lim);
    @(negedge clk);
    bus.cmd_dir   = dir;
    bus.cmd_load  = ld;
    bus.cmd_limit = lim;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_load  = 8'h00;
    bus.cmd_limit = 8'h00;
    bus.abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    #1;
    chk("reset_release/ready", {7'd0, bus.cmd_ready}, 8'd1);
`ifdef TFF_SEQ_AUTORELOAD_EN
    send(1'b1, 8'd0, 8'd3);
    push("ar.load0", 8'd0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 3; j++) push($sformatf("ar.p%0d.run%0d", p, j), 8'(j), 1'b1, 1'b0, 1'b0);
      push($sformatf("ar.p%0d.lim", p), 8'd3, 1'b1, 1'b1, 1'b0);
      push($sformatf("ar.p%0d.reload", p), 8'd3, 1'b1, 1'b0, 1'b0);
    end
    push("ar.run0", 8'd0, 1'b1, 1'b0, 1'b0);
    push("ar.run1", 8'd1, 1'b1, 1'b0, 1'b0);
    drain();
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    push("ar.abort0", 8'd1, 1'b0, 1'b0, 1'b1);
    push("ar.abort1", 8'd1, 1'b0, 1'b0, 1'b1);
    drain();
`else
    send(1'b1, 8'd3, 8'd7);
    trace("up3_7", 1'b1, 8'd3, 8'd7, -1);
    drain();
    send(1'b0, 8'd2, 8'd254);
    trace("dn2_254", 1'b0, 8'd2, 8'd254, -1);
    push("dn2_254.hold0", 8'd254, 1'b0, 1'b0, 1'b1);
    push("dn2_254.hold1", 8'd254, 1'b0, 1'b0, 1'b1);
    drain();
    send(1'b1, 8'hAA, 8'hAA);
    trace("eqAA", 1'b1, 8'hAA, 8'hAA, -1);
    drain();
    send(1'b1, 8'h55, 8'h55);
    trace("eq55", 1'b1, 8'h55, 8'h55, -1);
    drain();
    send(1'b1, 8'd0, 8'd10);
    trace("abort", 1'b1, 8'd0, 8'd10, 7);
    drain();
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) push($sformatf("abort.after%0d", i), 8'd5, 1'b0, 1'b0, 1'b1);
    drain();
    send(1'b0, 8'd5, 8'd3);
    trace("post_abort", 1'b0, 8'd5, 8'd3, -1);
    drain();
    @(negedge clk);
    bus.cmd_dir   = 1'b1;
    bus.cmd_load  = 8'd1;
    bus.cmd_limit = 8'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_load  = 8'd9;
    bus.cmd_limit = 8'd7;
    trace("holdA", 1'b1, 8'd1, 8'd3, -1);
    trace("holdB", 1'b0, 8'd9, 8'd7, -1);
    drain();
    bus.cmd_valid = 1'b0;
    send(1'b1, 8'd0, 8'd200);
    trace("midrst", 1'b1, 8'd0, 8'd200, 5);
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1;
    push("midrst.rst", 8'd0, 1'b0, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    @(posedge clk);
    #1;
    push("midrst.idle", 8'd0, 1'b0, 1'b0, 1'b1);
    drain();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
